max_pool_layer: RTL and testbench
=================================

MAX_POOL_LAYER -- requirements
Module: max_pool_layer

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the signed data width, matching the convolution layer N.
REQ-002 The block SHALL have parameter MaxRowSize, default 16383, giving the maximum input row width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start_i, input, 1 bit: begin a pooling pass.
REQ-006 The block SHALL have port row_size_i, input, $clog2(MaxRowSize+1) bits: input row width W, with height equal to W.
REQ-007 The block SHALL have port data_i, input, N bits signed: one convolution output sample, in row-major order.
REQ-008 The block SHALL have port valid_i, input, 1 bit: data_i is valid this cycle (driven from conv_valid_o).
REQ-009 The block SHALL have port data_o, output, N bits signed: pooled result.
REQ-010 The block SHALL have port valid_o, output, 1 bit: data_o is valid this cycle.
REQ-011 The block SHALL have port busy_o, output, 1 bit: a pass is in progress.
REQ-012 The block SHALL have port done_o, output, 1 bit: one-cycle pulse at the end of a pass.
REQ-013 The block SHALL have port assert_on_i, input, 1 bit: enables simulation assertions.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE -> RUN on start_i: latch W from row_size_i, and clear the column counter, row counter and holding register.
REQ-016 Each accepted sample SHALL advance the column counter by one in RUN; at col==W-1 the counter SHALL wrap to 0 and the row counter SHALL increment.
REQ-017 Samples with valid_i low SHALL NOT advance any state; arbitrary gaps between valid samples SHALL be tolerated.
REQ-018 valid_i SHALL be ignored in IDLE and DONE, and start_i SHALL be ignored in RUN and DONE.
REQ-019 At an even column the sample SHALL be stored in the holding register.
REQ-020 At an odd column, pair = max(hold, data_i).
REQ-021 At an odd column on an even row, pair SHALL be written to line-buffer entry col/2.
REQ-022 At an odd column on an odd row, data_o SHALL equal max(linebuf[col/2], pair), registered, with valid_o high in the cycle after the sample.
REQ-023 When W is odd, the last column and the last row SHALL be consumed but produce no output; the output count SHALL be floor(W/2)^2.
REQ-024 All comparisons SHALL be signed at N bits, and ties SHALL yield the equal value.
REQ-025 The last accepted sample (row==W-1, col==W-1) SHALL cause RUN -> DONE.
REQ-026 In DONE, done_o SHALL be high for exactly one cycle, coincident with the final valid_o when W is even; the FSM SHALL then go to IDLE.
REQ-027 busy_o SHALL be high in RUN and DONE.
REQ-028 The line buffer SHALL be ceil(MaxRowSize/2) entries of N bits, single write port and single read port, with no reset of its contents required.
REQ-029 When assert_on_i is high, W<2 or W>MaxRowSize at start_i SHALL raise $error, and valid_i with X data in RUN SHALL raise $error.

Reset
REQ-030 While rst_ni is low, the FSM SHALL be in IDLE and counters and the holding register SHALL be 0, with data_o=0, valid_o=0, busy_o=0 and done_o=0.
REQ-031 Reset asserted mid-pass SHALL abort the pass immediately with no done_o; the next start_i after release SHALL begin a clean pass.

Configuration
REQ-032 With macro AVG_POOL_EN defined, port mode_i (input, 1 bit, latched at start_i) SHALL be present.
REQ-033 With AVG_POOL_EN defined and the latched mode_i=1, the sum of four samples SHALL be formed at N+2 bits, and data_o SHALL equal sum>>>2 (arithmetic shift, floor) truncated to N bits; with the latched mode_i=0, the block SHALL perform max pooling.
REQ-034 Without AVG_POOL_EN, mode_i SHALL be absent, the block SHALL always perform max pooling, and the block SHALL contain no adder logic.

Verification
REQ-035 W=4, data 0..15 back-to-back -> outputs 5, 7, 13, 15; done_o with the 4th valid_o; busy_o then low.
REQ-036 W=5, data 0..24 -> outputs 6, 8, 16, 18; done_o one cycle after sample 24; no extra valid_o.
REQ-037 W=4, data -1..-16 -> outputs -1, -3, -9, -11.
REQ-038 W=4, data 0..15 with valid_i low every other cycle -> same four values as REQ-035; a start_i pulse mid-pass is ignored.
REQ-039 rst_ni low after 6 samples, then restart with W=4, data 0..15 -> outputs 5, 7, 13, 15 with no stale line-buffer effect.
REQ-040 With AVG_POOL_EN, mode_i=1, W=4, data 0..15 -> outputs 2, 4, 10, 12; data -1..-4 pattern -> floor rounding checked.

Source files
------------

// File: rtl/max_pool_layer_if.sv
// Stream/control bundle between the convolution layer and max_pool_layer.
// AVG_POOL_EN adds the mode_i select.
interface max_pool_layer_if #(
  parameter int N          = 8,
  parameter int MaxRowSize = 16383
);
  localparam int CW = $clog2(MaxRowSize + 1);

  logic                 start_i;
  logic [CW-1:0]        row_size_i;
  logic signed [N-1:0]  data_i;
  logic                 valid_i;
`ifdef AVG_POOL_EN
  logic                 mode_i;
`endif
  logic signed [N-1:0]  data_o;
  logic                 valid_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output start_i, row_size_i, data_i, valid_i,
`ifdef AVG_POOL_EN
    output mode_i,
`endif
    input  data_o, valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, row_size_i, data_i, valid_i,
`ifdef AVG_POOL_EN
    input  mode_i,
`endif
    output data_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/max_pool_layer.sv
// 2x2 stride-2 pooling over a WxW row-major stream using one half-row line buffer.
// Defining AVG_POOL_EN adds a latched mode_i selecting average pooling.
module max_pool_layer #(
  parameter int N          = 8,
  parameter int MaxRowSize = 16383
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  assert_on_i,
  max_pool_layer_if.slave       bus
);
  localparam int CW      = $clog2(MaxRowSize + 1);
  localparam int LbDepth = (MaxRowSize + 1) / 2;
  localparam int AW      = $clog2(LbDepth);
`ifdef AVG_POOL_EN
  localparam int LBW = N + 1;
`else
  localparam int LBW = N;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       w_q, col_q, row_q;
  logic signed [N-1:0] hold_q, data_q;
  logic                valid_q;
  logic                busy, done;
  logic [LBW-1:0]      linebuf [LbDepth];

  logic                accept, last_col, last_row;
  logic [AW-1:0]       lb_addr;
  logic [LBW-1:0]      lb_rd, lb_wr;
  logic signed [N-1:0] pair_max, lb_max, quad_max, pool_out;
`ifdef AVG_POOL_EN
  logic                mode_q;
  logic signed [N:0]   pair_sum;
  logic signed [N+1:0] quad_sum;
`endif

  assign accept   = (state_q == RUN) && bus.valid_i;
  assign last_col = (col_q == w_q - 1'b1);
  assign last_row = (row_q == w_q - 1'b1);
  assign lb_addr  = AW'(col_q >> 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start_i) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (accept && last_col && last_row) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Signed compares at N bits; a tie keeps hold/linebuf, which equals the other operand.
  always_comb begin
    pair_max = (bus.data_i > hold_q) ? bus.data_i : hold_q;
    lb_rd    = linebuf[lb_addr];
    lb_max   = $signed(lb_rd[N-1:0]);
    quad_max = (pair_max > lb_max) ? pair_max : lb_max;
`ifdef AVG_POOL_EN
    pair_sum = $signed({hold_q[N-1], hold_q}) + $signed({bus.data_i[N-1], bus.data_i});
    quad_sum = $signed({lb_rd[N], lb_rd}) + $signed({pair_sum[N], pair_sum});
    lb_wr    = mode_q ? pair_sum : {pair_max[N-1], pair_max};
    // Bits [N+1:2] of the sum are the floor of sum/4, truncated to N bits.
    pool_out = mode_q ? quad_sum[N+1:2] : quad_max;
`else
    lb_wr    = pair_max;
    pool_out = quad_max;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef AVG_POOL_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE && bus.start_i) begin
        w_q    <= bus.row_size_i;
        col_q  <= '0;
        row_q  <= '0;
        hold_q <= '0;
`ifdef AVG_POOL_EN
        mode_q <= bus.mode_i;
`endif
      end else if (accept) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (!col_q[0]) begin
          hold_q <= bus.data_i;
        end else if (row_q[0]) begin
          data_q  <= pool_out;
          valid_q <= 1'b1;
        end
      end
    end
  end

  // NOTE: the line buffer has no reset; every entry read on an odd row was written on the row above.
  always_ff @(posedge clk_i) begin
    if (accept && col_q[0] && !row_q[0]) linebuf[lb_addr] <= lb_wr;
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy;
  assign bus.done_o  = done;

  always @(posedge clk_i) begin
    if (rst_ni && assert_on_i) begin
      if (state_q == IDLE && bus.start_i)
        assert (bus.row_size_i >= 2 && int'(bus.row_size_i) <= MaxRowSize)
          else $error("max_pool_layer: row size %0d out of range", bus.row_size_i);
      if (state_q == RUN && bus.valid_i)
        assert (!$isunknown(bus.data_i))
          else $error("max_pool_layer: unknown data_i on a valid sample");
    end
  end
endmodule

// File: tb/tb_max_pool_layer.sv
// Directed bench for max_pool_layer: ramps, negatives, odd W, gaps, reset abort, extremes.
module tb_max_pool_layer;
  localparam int N  = 8;
  localparam int MR = 16383;
  localparam int CW = $clog2(MR + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic assert_on = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int stim[$];
  int expq[$];
  int outq[$];
  int done_cnt = 0;

  max_pool_layer_if #(.N(N), .MaxRowSize(MR)) bus ();

  max_pool_layer #(.N(N), .MaxRowSize(MR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .assert_on_i (assert_on),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.valid_o) outq.push_back(int'(bus.data_o));
    if (bus.done_o)  done_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic void ramp(input int base, input int step, input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(base + step * i);
  endfunction

  task automatic start_pass(input int w);
    outq.delete();
    bus.start_i    = 1'b1;
    bus.row_size_i = CW'(w);
    @(posedge clk); #1;
    bus.start_i    = 1'b0;
  endtask

  // Full pass: feed stim, then check done timing, idle return and the pooled stream.
  task automatic run_pass(input string tag, input int w, input bit gaps, input int mid_start);
    start_pass(w);
    check({tag, "_busy"}, int'(bus.busy_o), 1);
    for (int i = 0; i < stim.size(); i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = N'(stim[i]);
      @(posedge clk); #1;
      if (gaps && i != stim.size() - 1) begin
        bus.valid_i = 1'b0;
        if (i == mid_start) bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
      end
    end
    bus.valid_i = 1'b0;
    check({tag, "_done"}, int'(bus.done_o), 1);
    check({tag, "_valid_at_done"}, int'(bus.valid_o), (w % 2 == 0) ? 1 : 0);
    @(posedge clk); #1;
    check({tag, "_done_low"}, int'(bus.done_o), 0);
    check({tag, "_busy_low"}, int'(bus.busy_o), 0);
    check({tag, "_valid_low"}, int'(bus.valid_o), 0);
    check({tag, "_count"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      check($sformatf("%s_out%0d", tag, i), outq[i], expq[i]);
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.row_size_i = '0;
    bus.data_i     = '0;
    bus.valid_i    = 1'b0;
`ifdef AVG_POOL_EN
    bus.mode_i     = 1'b0;
`endif
    #12;
    check("rst_data", int'(bus.data_o), 0);
    check("rst_valid", int'(bus.valid_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // valid_i in IDLE must not start anything or produce output
    bus.valid_i = 1'b1;
    bus.data_i  = 8'sd99;
    repeat (3) @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    check("idle_valid_busy", int'(bus.busy_o), 0);
    check("idle_valid_out", outq.size(), 0);

    ramp(0, 1, 16);   expq = '{5, 7, 13, 15};
    run_pass("w4_ramp", 4, 1'b0, -1);

    ramp(0, 1, 25);   expq = '{6, 8, 16, 18};
    run_pass("w5_ramp", 5, 1'b0, -1);

    ramp(-1, -1, 16); expq = '{-1, -3, -9, -11};
    run_pass("w4_neg", 4, 1'b0, -1);

    ramp(0, 1, 16);   expq = '{5, 7, 13, 15};
    run_pass("w4_gaps", 4, 1'b1, 6);

    stim = '{-128, -128, -128, -128}; expq = '{-128};
    run_pass("w2_tie", 2, 1'b0, -1);

    stim = '{127, -128, -128, -128};  expq = '{127};
    run_pass("w2_signed", 2, 1'b0, -1);

    stim = '{-128, -128, -128, 127};  expq = '{127};
    run_pass("w2_last_max", 2, 1'b0, -1);

    // Abort a pass with reset after 6 samples, then run a clean pass.
    start_pass(4);
    for (int i = 0; i < 6; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = N'(100 + i);
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    check("abort_pre_valid", int'(bus.valid_o), 1);
    check("abort_pre_data", int'(bus.data_o), 105);
    rst_n = 1'b0;
    #1;
    check("abort_data", int'(bus.data_o), 0);
    check("abort_valid", int'(bus.valid_o), 0);
    check("abort_busy", int'(bus.busy_o), 0);
    check("abort_done", int'(bus.done_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_no_done", done_cnt, 7);
    ramp(0, 1, 16);   expq = '{5, 7, 13, 15};
    run_pass("w4_after_rst", 4, 1'b0, -1);

`ifdef AVG_POOL_EN
    bus.mode_i = 1'b1;
    ramp(0, 1, 16);   expq = '{2, 4, 10, 12};
    run_pass("avg_w4_ramp", 4, 1'b0, -1);
    stim = '{-1, -2, -3, -4};         expq = '{-3};
    run_pass("avg_w2_floor", 2, 1'b0, -1);
    stim = '{127, 127, 127, 127};     expq = '{127};
    run_pass("avg_w2_wide", 2, 1'b0, -1);
    bus.mode_i = 1'b0;
    ramp(0, 1, 16);   expq = '{5, 7, 13, 15};
    run_pass("avg_back_to_max", 4, 1'b0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
